// File: rtl/hazard_unit.sv
// Purpose : pipeline hazard control - load-use stall, operand bypass select, flush window, halt drain.
// Latency : stall_if/bubble/flush combinational from ID inputs; byp*_sel registered (valid for the EX consumer).
// Backpressure: stall_if holds PC and IM_ID; bubble turns the ID_EX entry into a NOP; halted is sticky until reset.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   id_valid/re0/re1/we/ld/hlt      - flags of the instruction currently in ID
//   id_p0_addr/p1_addr/dst_addr     - its source and destination registers
//   flow_change                     - taken branch/jump resolved in EX (one-cycle pulse)
//   stall_if, bubble, flush, halted - pipeline control outputs
//   byp0_sel, byp1_sel              - 0 = RF, k = producer k stages ahead of the EX consumer
module hazard_unit #(
  parameter int AW           = 4,
  parameter int BYP_STAGES   = 2,
  parameter int LD_LAT       = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_re0,
  input  logic          id_re1,
  input  logic          id_we,
  input  logic          id_ld,
  input  logic          id_hlt,
  input  logic [AW-1:0] id_p0_addr,
  input  logic [AW-1:0] id_p1_addr,
  input  logic [AW-1:0] id_dst_addr,
  input  logic          flow_change,
  output logic          stall_if,
  output logic          bubble,
  output logic [2:0]    byp0_sel,
  output logic [2:0]    byp1_sel,
  output logic          flush,
  output logic          halted
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  typedef struct packed {
    logic          we;
    logic          ld;
    logic [AW-1:0] dst;
  } shadow_t;

  // Entry 0 mirrors EX, entry i mirrors EX+i.
  shadow_t                 sh_q [BYP_STAGES];
  shadow_t                 ent_in;
  logic [BYP_STAGES-1:0]   m0;
  logic [BYP_STAGES-1:0]   m1;
  logic                    hazard;
  logic [2:0]              sel0_nxt;
  logic [2:0]              sel1_nxt;
  logic [2:0]              fcnt_q;
  logic [2:0]              dcnt_q;
  logic [1:0]              state_q;
  logic                    run;
  logic                    go_halt;

  assign run = (state_q == RUN);

  // Source/entry match; R0 is hard-wired zero so it is never forwarded.
  always_comb begin
    m0 = '0;
    m1 = '0;
    for (int i = 0; i < BYP_STAGES; i++) begin
      m0[i] = id_re0 && (id_p0_addr != '0) && sh_q[i].we && (sh_q[i].dst == id_p0_addr);
      m1[i] = id_re1 && (id_p1_addr != '0) && sh_q[i].we && (sh_q[i].dst == id_p1_addr);
    end
  end

  // Load-use: a load whose data is not yet forwardable (entry index below LD_LAT).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < BYP_STAGES; i++) begin
      if ((i < LD_LAT) && sh_q[i].ld && (m0[i] || m1[i])) hazard = 1'b1;
    end
    hazard = hazard && id_valid;
  end

  // Youngest matching producer wins: scan oldest to youngest so the lowest index lands last.
  always_comb begin
    sel0_nxt = 3'd0;
    sel1_nxt = 3'd0;
    for (int i = BYP_STAGES - 1; i >= 0; i--) begin
      if (m0[i]) sel0_nxt = 3'(i + 1);
      if (m1[i]) sel1_nxt = 3'(i + 1);
    end
  end

  // Flow changes only count while running; DRAIN/HALTED ignore them.
  assign flush   = run && (flow_change || (fcnt_q != 3'd0));
  assign go_halt = run && id_valid && id_hlt && !flush && !hazard;

  // Flush beats load-use on stall_if so the redirected fetch is not held.
  always_comb begin
    stall_if = 1'b1;
    bubble   = 1'b1;
    if (run) begin
      stall_if = hazard && !flush;
      bubble   = hazard || flush;
    end
  end

  assign halted = (state_q == HALTED);

  always_comb begin
    ent_in = '0;
    if (!bubble) begin
      ent_in.we  = id_we && id_valid;
      ent_in.ld  = id_ld && id_valid;
      ent_in.dst = id_dst_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BYP_STAGES; i++) sh_q[i] <= '0;
      byp0_sel <= 3'd0;
      byp1_sel <= 3'd0;
    end else begin
      sh_q[0] <= ent_in;
      for (int i = 1; i < BYP_STAGES; i++) sh_q[i] <= sh_q[i-1];
      byp0_sel <= sel0_nxt;
      byp1_sel <= sel1_nxt;
    end
  end

  // Flush window: reloads (never accumulates) on each flow change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 3'd0;
    end else if (run && flow_change) begin
      fcnt_q <= 3'(FLUSH_CYCLES - 1);
    end else if (fcnt_q != 3'd0) begin
      fcnt_q <= fcnt_q - 3'd1;
    end
  end

  // Halt FSM: DRAIN lasts BYP_STAGES+1 cycles so every in-flight instruction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      dcnt_q  <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (go_halt) begin
            state_q <= DRAIN;
            dcnt_q  <= 3'(BYP_STAGES);
          end
        end
        DRAIN: begin
          if (dcnt_q == 3'd0) state_q <= HALTED;
          else                dcnt_q  <= dcnt_q - 3'd1;
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Purpose : directed self-checking bench for hazard_unit (default and LD_LAT=2/BYP_STAGES=3 builds).
// Latency : n/a.
// Backpressure: n/a.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_re0, id_re1, id_we, id_ld, id_hlt;
  logic [3:0] id_p0_addr, id_p1_addr, id_dst_addr;
  logic       flow_change;

  logic       stall_if, bubble, flush, halted;
  logic [2:0] byp0_sel, byp1_sel;
  logic       b_stall_if, b_bubble, b_flush, b_halted;
  logic [2:0] b_byp0_sel, b_byp1_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_re0(id_re0), .id_re1(id_re1), .id_we(id_we),
    .id_ld(id_ld), .id_hlt(id_hlt),
    .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr), .id_dst_addr(id_dst_addr),
    .flow_change(flow_change),
    .stall_if(stall_if), .bubble(bubble), .byp0_sel(byp0_sel), .byp1_sel(byp1_sel),
    .flush(flush), .halted(halted)
  );

  hazard_unit #(.AW(4), .BYP_STAGES(3), .LD_LAT(2), .FLUSH_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_re0(id_re0), .id_re1(id_re1), .id_we(id_we),
    .id_ld(id_ld), .id_hlt(id_hlt),
    .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr), .id_dst_addr(id_dst_addr),
    .flow_change(flow_change),
    .stall_if(b_stall_if), .bubble(b_bubble), .byp0_sel(b_byp0_sel), .byp1_sel(b_byp1_sel),
    .flush(b_flush), .halted(b_halted)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r0, input logic [3:0] a0,
                       input logic r1, input logic [3:0] a1,
                       input logic we, input logic ld, input logic [3:0] dst,
                       input logic hlt);
    id_valid = v;  id_re0 = r0; id_p0_addr = a0;
    id_re1 = r1;   id_p1_addr = a1;
    id_we = we;    id_ld = ld;  id_dst_addr = dst;
    id_hlt = hlt;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
    flow_change = 1'b0;
  endtask

  // Sample point: 1 time unit after the rising edge, registered outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    // Reset state
    rst_n = 1'b0;
    tick();
    check("rst_stall", stall_if, 0);
    check("rst_bubble", bubble, 0);
    check("rst_flush", flush, 0);
    check("rst_halted", halted, 0);
    check("rst_byp0", byp0_sel, 0);
    check("rst_byp1", byp1_sel, 0);
    rst_n = 1'b1;

    // LW R3 ; ADD R4,R3,R1 -> one stall cycle, then forward from DM
    drive(1, 0, 4'd0, 0, 4'd0, 1, 1, 4'd3, 0);
    #1 check("lw_nostall", stall_if, 0);
    tick();
    drive(1, 1, 4'd3, 1, 4'd1, 1, 0, 4'd4, 0);
    #1 check("lu_stall", stall_if, 1);
    check("lu_bubble", bubble, 1);
    tick();
    check("lu_stall_c2", stall_if, 0);
    check("lu_bubble_c2", bubble, 0);
    tick();
    check("lu_byp0", byp0_sel, 2);
    check("lu_byp1", byp1_sel, 0);

    // ADD R5 ; SUB p1=R5 -> no stall, forward from EX
    do_reset();
    drive(1, 0, 4'd0, 0, 4'd0, 1, 0, 4'd5, 0);
    tick();
    drive(1, 1, 4'd2, 1, 4'd5, 1, 0, 4'd6, 0);
    #1 check("alu_nostall", stall_if, 0);
    tick();
    check("alu_byp1", byp1_sel, 1);
    check("alu_byp0", byp0_sel, 0);
    // Load into R0 then read R0: no stall, no bypass
    drive(1, 0, 4'd0, 0, 4'd0, 1, 1, 4'd0, 0);
    tick();
    drive(1, 1, 4'd0, 1, 4'd0, 0, 0, 4'd0, 0);
    #1 check("r0_nostall", stall_if, 0);
    tick();
    check("r0_byp0", byp0_sel, 0);
    check("r0_byp1", byp1_sel, 0);

    // R2 producers in EX and DM -> youngest (EX) wins
    do_reset();
    drive(1, 0, 4'd0, 0, 4'd0, 1, 0, 4'd2, 0);
    tick();
    tick();
    drive(1, 1, 4'd2, 1, 4'd2, 0, 0, 4'd0, 0);
    tick();
    check("young_byp0", byp0_sel, 1);
    check("young_byp1", byp1_sel, 1);

    // Single flow change -> 2-cycle flush
    do_reset();
    flow_change = 1'b1;
    #1 check("fl1_c0_flush", flush, 1);
    check("fl1_c0_bubble", bubble, 1);
    tick();
    flow_change = 1'b0;
    check("fl1_c1_flush", flush, 1);
    check("fl1_c1_bubble", bubble, 1);
    tick();
    check("fl1_c2_flush", flush, 0);
    check("fl1_c2_bubble", bubble, 0);
    // Back-to-back pulses -> 3-cycle window
    flow_change = 1'b1;
    tick();
    check("fl2_c1_flush", flush, 1);
    tick();
    flow_change = 1'b0;
    check("fl2_c2_flush", flush, 1);
    tick();
    check("fl2_c3_flush", flush, 0);
    // Flush together with load-use: fetch not held
    drive(1, 0, 4'd0, 0, 4'd0, 1, 1, 4'd3, 0);
    tick();
    drive(1, 1, 4'd3, 0, 4'd0, 1, 0, 4'd4, 0);
    flow_change = 1'b1;
    #1 check("fl_lu_stall", stall_if, 0);
    check("fl_lu_bubble", bubble, 1);
    tick();
    idle();

    // HLT -> 3 drain cycles, then sticky halt
    do_reset();
    drive(1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1);
    #1 check("hlt_bubble", bubble, 0);
    check("hlt_stall", stall_if, 0);
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("drain%0d_stall", c), stall_if, 1);
      check($sformatf("drain%0d_bubble", c), bubble, 1);
      check($sformatf("drain%0d_halted", c), halted, 0);
      tick();
    end
    check("halted_set", halted, 1);
    check("halted_stall", stall_if, 1);
    flow_change = 1'b1;
    #1 check("halted_noflush", flush, 0);
    tick();
    flow_change = 1'b0;
    tick();
    check("halted_sticky", halted, 1);

    // Reset mid-drain -> clean RUN
    do_reset();
    drive(1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1);
    tick();
    idle();
    tick();
    do_reset();
    check("rst_drain_stall", stall_if, 0);
    check("rst_drain_bubble", bubble, 0);
    tick();
    tick();
    tick();
    tick();
    check("rst_drain_halted", halted, 0);

    // HLT inside flush window is killed
    do_reset();
    flow_change = 1'b1;
    tick();
    flow_change = 1'b0;
    drive(1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1);
    #1 check("hlt_fl_bubble", bubble, 1);
    tick();
    idle();
    for (int c = 0; c < 5; c++) tick();
    check("hlt_fl_halted", halted, 0);
    check("hlt_fl_stall", stall_if, 0);

    // Reset mid-flush
    do_reset();
    flow_change = 1'b1;
    tick();
    flow_change = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_fl_flush", flush, 0);
    tick();
    rst_n = 1'b1;
    #1 check("rst_fl_flush_rel", flush, 0);
    check("rst_fl_bubble_rel", bubble, 0);

    // LD_LAT=2, BYP_STAGES=3: two stall cycles then forward from stage 3
    do_reset();
    drive(1, 0, 4'd0, 0, 4'd0, 1, 1, 4'd3, 0);
    tick();
    drive(1, 1, 4'd3, 0, 4'd0, 1, 0, 4'd4, 0);
    #1 check("b_stall_c1", b_stall_if, 1);
    tick();
    check("b_stall_c2", b_stall_if, 1);
    tick();
    check("b_stall_c3", b_stall_if, 0);
    tick();
    check("b_byp0", b_byp0_sel, 3);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
